layer_mux_n: RTL
================

LAYER_MUX_N -- requirements
Module: layer_mux_n

Interface
REQ-001 Parameter NUM_LAYERS, default 4, sets the number of drawing layers; legal range is 2..8.
REQ-002 Parameter RGB_W, default 8, sets the pixel colour width.
REQ-003 Parameter KEY_RGB, default 0, is the transparent colour key.
REQ-004 Parameter BG_RGB, default 0, is the colour output when no layer wins.
REQ-005 Parameter BLINK_FRAMES, default 16, is the number of frames per blink half-period; legal range is 1 or more.
REQ-006 IDX_W SHALL be derived as clog2(NUM_LAYERS), with a minimum of 1.
REQ-007 clk, input, 1 bit: pixel clock.
REQ-008 resetN, input, 1 bit: reset, asynchronous, active-low.
REQ-009 draw_req, input, NUM_LAYERS bits: per-layer drawing request; bit i belongs to layer i.
REQ-010 rgb_in, input, NUM_LAYERS*RGB_W bits: per-layer colour; layer i occupies bits [i*RGB_W +: RGB_W].
REQ-011 layer_en, input, NUM_LAYERS bits: static per-layer enable.
REQ-012 blink_en, input, NUM_LAYERS bits: the layer is subject to blink masking.
REQ-013 frame_start, input, 1 bit: one-cycle pulse at the first pixel of each frame.
REQ-014 cfg_valid, input, 1 bit: a new priority order is offered.
REQ-015 cfg_order, input, NUM_LAYERS*IDX_W bits: field k holds the layer index at rank k, with rank 0 highest.
REQ-016 cfg_ready, output, 1 bit: the block can accept a new order.
REQ-017 DrawingRequest, output, 1 bit: registered flag; some layer won.
REQ-018 RGBOut, output, RGB_W bits: registered output colour.
REQ-019 hit_layer, output, IDX_W bits: registered index of the winning layer; 0 when no layer wins.

Function
REQ-020 A layer i SHALL be eligible only when all of the following hold:
- draw_req[i]=1;
- layer_en[i]=1;
- rgb_in for layer i differs from KEY_RGB;
- blink_en[i]=0, or blink_phase=0.
REQ-021 The winner SHALL be the eligible layer at the lowest rank in the active order.
- Duplicate entries are legal; the lowest rank wins.
- A layer absent from the order never wins.
- An order entry with index at or above NUM_LAYERS never matches.
REQ-022 With a winner, the outputs on the next clock edge SHALL be: RGBOut = winner colour, DrawingRequest=1, hit_layer = winner index.
REQ-023 With no winner, the outputs on the next clock edge SHALL be: RGBOut=BG_RGB, DrawingRequest=0, hit_layer=0.
REQ-024 Latency SHALL be exactly 1 clock from the inputs to all three outputs, at full throughput.
REQ-025 DrawingRequest SHALL be derived from the arbitration result and never from the RGBOut value, so a winning colour equal to 0 still drives DrawingRequest=1.
REQ-026 The config handshake SHALL use two states:
- IDLE: cfg_ready=1.
- PENDING: cfg_ready=0.
REQ-027 In IDLE, cfg_valid=1 SHALL capture cfg_order into a shadow register and move the block to PENDING.
REQ-028 In PENDING, the block SHALL ignore cfg_valid.
REQ-029 In PENDING, on frame_start the shadow register SHALL be copied to the active order and the block SHALL return to IDLE; the new order governs arbitration from the following cycle.
REQ-030 If cfg_valid and frame_start occur together in IDLE, the order SHALL be captured and applied at the next frame_start, not the current one.
REQ-031 The pixel that coincides with frame_start SHALL use the old order and the old blink_phase.
REQ-032 Blink counter blink_cnt SHALL be clog2(BLINK_FRAMES) bits wide, with a minimum of 1.
REQ-033 On each frame_start, blink_cnt SHALL behave as follows:
- if blink_cnt = BLINK_FRAMES-1: clear it to 0 and toggle blink_phase;
- otherwise: increment it.
REQ-034 With BLINK_FRAMES=1, blink_phase SHALL toggle on every frame_start.
REQ-035 blink_cnt and blink_phase SHALL change only on frame_start.

Reset
REQ-036 While resetN=0, all of the following SHALL hold:
- RGBOut=BG_RGB, DrawingRequest=0, hit_layer=0;
- blink_cnt=0, blink_phase=0;
- FSM=IDLE, so cfg_ready=1;
- active and shadow orders set to identity, with rank k = layer k.
REQ-037 Reset asserted mid-frame or while in PENDING SHALL discard the pending order.
REQ-038 After resetN rises, the first clock edge SHALL produce normal arbitration output.

Verification
REQ-039 Priority test, with NUM_LAYERS=4, identity order, draw_req=4'b1010, layer 1 colour 0x1C, layer 3 colour 0xE0 -> next cycle RGBOut=0x1C, hit_layer=1, DrawingRequest=1.
REQ-040 Colour-key test, with layer 1 colour equal to KEY_RGB=0x00 and the other inputs as in REQ-039 -> RGBOut=0xE0, hit_layer=3, DrawingRequest=1.
REQ-041 Reorder test: offer order {3,2,1,0} mid-frame.
- cfg_ready drops to 0 immediately.
- Output stays 0x1C until the cycle after frame_start.
- Output then becomes 0xE0, and cfg_ready returns to 1.
REQ-042 Blink test, with BLINK_FRAMES=2, blink_en[1]=1 and the inputs as in REQ-039:
- frames 0-1 output 0x1C;
- after the 2nd frame_start, output is 0xE0;
- after the 4th frame_start, output is 0x1C.
REQ-043 Empty test: draw_req=0 with BG_RGB=0x25 -> RGBOut=0x25, DrawingRequest=0, hit_layer=0.
REQ-044 Reset test: assert resetN=0 while in PENDING -> outputs clear asynchronously and cfg_ready=1; a following frame_start leaves the identity order in force.

Source files
------------

// File: rtl/layer_mux_n_if.sv
// ---------------------------------------------------------------------------
// layer_mux_n_if
// Bundles the per-pixel layer inputs, the priority-order configuration
// handshake and the registered mux outputs of layer_mux_n.
//   draw_req / layer_en / blink_en : NUM_LAYERS bits, bit i = layer i
//   rgb_in      : NUM_LAYERS*RGB_W, layer i at [i*RGB_W +: RGB_W]
//   frame_start : one-cycle pulse on the first pixel of a frame
//   cfg_valid / cfg_order / cfg_ready : priority-order offer handshake,
//                 cfg_order field k = layer index at rank k (rank 0 highest)
//   DrawingRequest / RGBOut / hit_layer : registered arbitration result
// Modports: master = pixel/config source, slave = layer_mux_n.
// ---------------------------------------------------------------------------
interface layer_mux_n_if #(
   parameter int NUM_LAYERS = 4,
   parameter int RGB_W      = 8
);
   localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   logic [NUM_LAYERS-1:0]       draw_req;
   logic [NUM_LAYERS*RGB_W-1:0] rgb_in;
   logic [NUM_LAYERS-1:0]       layer_en;
   logic [NUM_LAYERS-1:0]       blink_en;
   logic                        frame_start;
   logic                        cfg_valid;
   logic [NUM_LAYERS*IDX_W-1:0] cfg_order;
   logic                        cfg_ready;
   logic                        DrawingRequest;
   logic [RGB_W-1:0]            RGBOut;
   logic [IDX_W-1:0]            hit_layer;

   modport master (
      output draw_req, rgb_in, layer_en, blink_en, frame_start,
             cfg_valid, cfg_order,
      input  cfg_ready, DrawingRequest, RGBOut, hit_layer
   );

   modport slave (
      input  draw_req, rgb_in, layer_en, blink_en, frame_start,
             cfg_valid, cfg_order,
      output cfg_ready, DrawingRequest, RGBOut, hit_layer
   );
endinterface

// File: rtl/layer_mux_n.sv
// ---------------------------------------------------------------------------
// layer_mux_n
// Priority multiplexer for NUM_LAYERS drawing layers. Each pixel the
// eligible layer with the best rank in the active priority order drives the
// registered output colour; otherwise the background colour is output.
// A layer is eligible when it requests drawing, is enabled, its colour is
// not the transparent key, and it is not blanked by the blink phase.
// A new priority order is captured into a shadow register through a
// ready/valid handshake and only becomes active at the next frame_start,
// so an order change never tears a frame.
// Ports:
//   clk    : pixel clock
//   resetN : asynchronous, active-low reset
//   bus    : layer_mux_n_if.slave (layer inputs, config handshake, outputs)
// ---------------------------------------------------------------------------
module layer_mux_n #(
   parameter int               NUM_LAYERS   = 4,
   parameter int               RGB_W        = 8,
   parameter logic [RGB_W-1:0] KEY_RGB      = '0,
   parameter logic [RGB_W-1:0] BG_RGB       = '0,
   parameter int               BLINK_FRAMES = 16
)(
   input  logic         clk,
   input  logic         resetN,
   layer_mux_n_if.slave bus
);

   localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int ORD_W = NUM_LAYERS * IDX_W;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } cfg_state_t;

   // Identity order: rank k holds layer k.
   function automatic logic [ORD_W-1:0] identity_order();
      logic [ORD_W-1:0] o;
      o = '0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
         o[k*IDX_W +: IDX_W] = IDX_W'(k);
      end
      return o;
   endfunction

   function automatic logic is_eligible(
      input logic             req,
      input logic             en,
      input logic             blink,
      input logic             phase,
      input logic [RGB_W-1:0] rgb
   );
      return req & en & (rgb != KEY_RGB) & (~blink | ~phase);
   endfunction

   cfg_state_t        state, state_nxt;
   logic              cfg_ready_c;
   logic              capture;
   logic              apply;
   logic [ORD_W-1:0]  order_shd;
   logic [ORD_W-1:0]  order_act;

   logic [CNT_W-1:0]  blink_cnt;
   logic              blink_phase;

   logic [NUM_LAYERS-1:0] elig_p0;
   logic [IDX_W-1:0]      rank_idx_p0;
   logic                  win_vld_p0;
   logic [IDX_W-1:0]      win_idx_p0;
   logic [RGB_W-1:0]      win_rgb_p0;

   logic                  vld_p1;
   logic [IDX_W-1:0]      hit_p1;
   logic [RGB_W-1:0]      rgb_p1;

   // ---- stage p0: eligibility and rank search (combinational) ----
   // blink_phase and order_act are the registered values, so the pixel that
   // coincides with frame_start still sees the previous frame's settings.
   always_comb begin
      elig_p0 = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         elig_p0[i] = is_eligible(bus.draw_req[i], bus.layer_en[i],
                                  bus.blink_en[i], blink_phase,
                                  bus.rgb_in[i*RGB_W +: RGB_W]);
      end
   end

   // Walk from the lowest priority rank upwards so the best matching rank is
   // the last to assign; duplicates therefore resolve to the lowest rank and
   // indices outside the layer range are skipped.
   always_comb begin
      rank_idx_p0 = '0;
      win_vld_p0  = 1'b0;
      win_idx_p0  = '0;
      win_rgb_p0  = BG_RGB;
      for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
         rank_idx_p0 = order_act[k*IDX_W +: IDX_W];
         if (int'(rank_idx_p0) < NUM_LAYERS) begin
            if (elig_p0[rank_idx_p0]) begin
               win_vld_p0 = 1'b1;
               win_idx_p0 = rank_idx_p0;
               win_rgb_p0 = bus.rgb_in[int'(rank_idx_p0)*RGB_W +: RGB_W];
            end
         end
      end
   end

   // ---- stage p1: registered outputs ----
   // DrawingRequest comes from the win flag, not from the colour, so a
   // winning colour that happens to be zero still reports a hit.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         vld_p1 <= 1'b0;
         hit_p1 <= '0;
         rgb_p1 <= BG_RGB;
      end else begin
         vld_p1 <= win_vld_p0;
         hit_p1 <= win_idx_p0;
         rgb_p1 <= win_rgb_p0;
      end
   end

   assign bus.DrawingRequest = vld_p1;
   assign bus.hit_layer      = hit_p1;
   assign bus.RGBOut         = rgb_p1;

   // Config handshake state register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Apply is only possible from PENDING, so an offer arriving together
   // with frame_start in IDLE waits for the following frame_start.
   always_comb begin
      state_nxt   = state;
      cfg_ready_c = 1'b0;
      capture     = 1'b0;
      apply       = 1'b0;
      case (state)
         IDLE: begin
            cfg_ready_c = 1'b1;
            if (bus.cfg_valid) begin
               capture   = 1'b1;
               state_nxt = PENDING;
            end
         end
         PENDING: begin
            if (bus.frame_start) begin
               apply     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.cfg_ready = cfg_ready_c;

   // Shadow and active priority orders; reset discards any pending order.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         order_shd <= identity_order();
         order_act <= identity_order();
      end else begin
         if (capture) begin
            order_shd <= bus.cfg_order;
         end
         if (apply) begin
            order_act <= order_shd;
         end
      end
   end

   // Blink timing advances once per frame; the phase flips every
   // BLINK_FRAMES frames (every frame when BLINK_FRAMES is 1).
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (bus.frame_start) begin
         if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

endmodule
